// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_arbiter
// Description : Owns the single frame-buffer write port. Grants it either to
//               the full-screen clear engine or, round-robin, to one of two
//               bike-trail requesters. Pixel coordinates are converted into
//               packed word addresses (4 bpp, two pixels per 16-bit word) and
//               trail colors are replicated into both pixel slots of the word.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
    parameter logic [3:0] CLEAR_COLOR = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        clear_start,
    output logic        clear_busy,
    input  logic        p0_req,
    input  logic [9:0]  p0_x,
    input  logic [9:0]  p0_y,
    input  logic [3:0]  p0_color,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic [9:0]  p1_x,
    input  logic [9:0]  p1_y,
    input  logic [3:0]  p1_color,
    output logic        p1_ack,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [15:0] fb_data
);

    // Controller states
    localparam logic [0:0]  c_ST_IDLE    = 1'b0;
    localparam logic [0:0]  c_ST_CLEAR   = 1'b1;

    // Geometry: 640x480 pixels, 320 words per line, 153600 words total
    localparam logic [17:0] c_LAST_WORD  = 18'd153599;
    localparam logic [9:0]  c_X_LIMIT    = 10'd640;
    localparam logic [9:0]  c_Y_LIMIT    = 10'd480;

    // Word written to every location during a clear
    localparam logic [15:0] c_CLEAR_WORD = {4'h0, CLEAR_COLOR, 4'h0, CLEAR_COLOR};

    logic [0:0]  r_state;
    // Address of the NEXT clear write; the entry cycle itself writes word 0.
    logic [17:0] r_clear_cnt;
    // Last requester granted: 0 = player 0, 1 = player 1
    logic        r_last_grant;

    logic        w_p0_elig;
    logic        w_p1_elig;
    logic        w_grant_p0;
    logic        w_grant_p1;
    logic [18:0] w_p0_addr;
    logic [18:0] w_p1_addr;
    logic        w_p0_in_range;
    logic        w_p1_in_range;
    logic [18:0] w_sel_addr;
    logic [15:0] w_sel_data;
    logic        w_sel_in_range;

    // Word address = y*320 + x/2, built from shifts so no multiplier is needed
    function automatic logic [18:0] f_word_addr(input logic [9:0] x, input logic [9:0] y);
        logic [18:0] y_ext;
        y_ext = {9'd0, y};
        return (y_ext << 8) + (y_ext << 6) + {10'd0, x[9:1]};
    endfunction

    // Trail writes paint both pixels of the word with the same color
    function automatic logic [15:0] f_trail_word(input logic [3:0] color);
        return {4'h0, color, 4'h0, color};
    endfunction

    assign w_p0_addr     = f_word_addr(p0_x, p0_y);
    assign w_p1_addr     = f_word_addr(p1_x, p1_y);
    assign w_p0_in_range = (p0_x < c_X_LIMIT) && (p0_y < c_Y_LIMIT);
    assign w_p1_in_range = (p1_x < c_X_LIMIT) && (p1_y < c_Y_LIMIT);

    // A request still visible in its own ack cycle must not be served twice,
    // so a requester with its ack register set sits out one cycle.
    assign w_p0_elig  = p0_req && !p0_ack;
    assign w_p1_elig  = p1_req && !p1_ack;

    // Round-robin: on a tie the requester that was not granted last wins
    assign w_grant_p0 = w_p0_elig && (!w_p1_elig ||  r_last_grant);
    assign w_grant_p1 = w_p1_elig && (!w_p0_elig || !r_last_grant);

    // Fields of whichever requester is granted this cycle
    assign w_sel_addr     = w_grant_p1 ? w_p1_addr     : w_p0_addr;
    assign w_sel_data     = w_grant_p1 ? f_trail_word(p1_color) : f_trail_word(p0_color);
    assign w_sel_in_range = w_grant_p1 ? w_p1_in_range : w_p0_in_range;

    // Controller: clear sequencing, bike arbitration and registered write port
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state      <= c_ST_IDLE;
            r_clear_cnt  <= 18'd0;
            r_last_grant <= 1'b1;
            clear_busy   <= 1'b0;
            p0_ack       <= 1'b0;
            p1_ack       <= 1'b0;
            fb_we        <= 1'b0;
            fb_addr      <= 19'd0;
            fb_data      <= 16'd0;
        end else begin
            // Strobes default low; they are single-cycle pulses
            fb_we  <= 1'b0;
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (clear_start) begin
                        // Clear beats any pending bike request; word 0 goes
                        // out immediately so the clear starts without a bubble.
                        r_state     <= c_ST_CLEAR;
                        clear_busy  <= 1'b1;
                        fb_we       <= 1'b1;
                        fb_addr     <= 19'd0;
                        fb_data     <= c_CLEAR_WORD;
                        r_clear_cnt <= 18'd1;
                    end else begin
                        clear_busy <= 1'b0;
                        if (w_grant_p0 || w_grant_p1) begin
                            p0_ack       <= w_grant_p0;
                            p1_ack       <= w_grant_p1;
                            r_last_grant <= w_grant_p1;
                            // Off-screen requests are consumed but not written
                            if (w_sel_in_range) begin
                                fb_we   <= 1'b1;
                                fb_addr <= w_sel_addr;
                                fb_data <= w_sel_data;
                            end
                        end
                    end
                end

                c_ST_CLEAR: begin
                    // One word per cycle; bike requests wait unacknowledged
                    fb_we       <= 1'b1;
                    fb_addr     <= {1'b0, r_clear_cnt};
                    fb_data     <= c_CLEAR_WORD;
                    r_clear_cnt <= r_clear_cnt + 18'd1;
                    if (r_clear_cnt == c_LAST_WORD) begin
                        // clear_busy drops on the next edge, together with
                        // the first possible bike grant.
                        r_state     <= c_ST_IDLE;
                        r_clear_cnt <= 18'd0;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
